// File: rtl/fetch_if.sv
// fetch_if: fetch-unit bus bundling the redirect, instruction-memory and insn-FIFO write signals.
interface fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                           i_redirect;
    logic [ADDR_WIDTH-1:0]          i_redirect_addr;
    logic                           o_ic_en;
    logic [ADDR_WIDTH-1:0]          o_ic_addr;
    logic                           i_ic_valid;
    logic [DATA_WIDTH-1:0]          i_ic_data;
    logic                           o_fifo_wr_en;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_fifo_data_in;
    logic                           i_fifo_full;
    modport master (
        input  i_redirect, i_redirect_addr, i_ic_valid, i_ic_data, i_fifo_full,
        output o_ic_en, o_ic_addr, o_fifo_wr_en, o_fifo_data_in
    );
    modport slave (
        output i_redirect, i_redirect_addr, i_ic_valid, i_ic_data, i_fifo_full,
        input  o_ic_en, o_ic_addr, o_fifo_wr_en, o_fifo_data_in
    );
endinterface

// File: rtl/fetch.sv
// fetch: single-outstanding instruction fetcher feeding {pc, insn} into the instruction FIFO.
module fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input logic     clk,
    input logic     n_rst,
    fetch_if.master bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] hold;
    logic                  wr;
    // Write and request are same-cycle reactions, so outputs decode the registered state.
    assign wr = n_rst && !bus.i_redirect && !bus.i_fifo_full &&
                ((state == WAIT && bus.i_ic_valid) || state == HOLD);
    assign bus.o_fifo_wr_en   = wr;
    assign bus.o_ic_en        = n_rst && !bus.i_redirect && state == REQ;
    assign bus.o_ic_addr      = pc;
    assign bus.o_fifo_data_in = n_rst ? {pc, state == HOLD ? hold : bus.i_ic_data} : '0;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= REQ;
            pc    <= RESET_ADDR;
            hold  <= '0;
        end else if (bus.i_redirect) begin
            // An unanswered request must have its response swallowed in DROP.
            state <= ((state == WAIT || state == DROP) && !bus.i_ic_valid) ? DROP : REQ;
            pc    <= bus.i_redirect_addr;
            hold  <= '0;
        end else begin
            if (wr)
                pc <= pc + ADDR_WIDTH'(4);
            if (state == WAIT && bus.i_ic_valid && bus.i_fifo_full)
                hold <= bus.i_ic_data;
            case (state)
                REQ:  state <= WAIT;
                WAIT: state <= bus.i_ic_valid ? (bus.i_fifo_full ? HOLD : REQ) : WAIT;
                HOLD: state <= bus.i_fifo_full ? HOLD : REQ;
                DROP: state <= bus.i_ic_valid ? REQ : DROP;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for fetch with a variable-latency instruction memory model.
module tb_fetch;
    logic clk = 1'b0;
    logic n_rst;
    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cnt = 0;
    bit mem_fixed = 1'b1;
    logic [31:0] salt = '0;
    logic [31:0] m_addr = '0;
    logic [63:0] exp_q[$];
    logic [63:0] m_exp;
    bit found;
    logic [31:0] req_addr;

    fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_ADDR(32'h0)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return mem_fixed ? 32'h13 : (~a ^ salt);
    endfunction

    // Instruction memory: answers each accepted request after lat cycles.
    always @(posedge clk) begin
        if (!n_rst) begin
            bus.i_ic_valid <= 1'b0;
            cnt <= 0;
        end else if (bus.o_ic_en) begin
            m_addr <= bus.o_ic_addr;
            if (lat == 1) begin
                bus.i_ic_valid <= 1'b1;
                bus.i_ic_data  <= memf(bus.o_ic_addr);
                cnt <= 0;
            end else begin
                bus.i_ic_valid <= 1'b0;
                cnt <= lat - 1;
            end
        end else if (cnt == 1) begin
            bus.i_ic_valid <= 1'b1;
            bus.i_ic_data  <= memf(m_addr);
            cnt <= 0;
        end else begin
            bus.i_ic_valid <= 1'b0;
            if (cnt > 0) cnt <= cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (bus.o_fifo_wr_en) begin
            checks++;
            if (bus.i_fifo_full) begin
                errors++;
                $display("FAIL wr_while_full: wr_en=1 with full=1, required wr_en=0");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_write: unexpected write %h, required none", bus.o_fifo_data_in);
            end else begin
                m_exp = exp_q.pop_front();
                if (bus.o_fifo_data_in !== m_exp) begin
                    errors++;
                    $display("FAIL fifo_write: got %h required %h", bus.o_fifo_data_in, m_exp);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        bus.i_redirect = 1'b0;
        bus.i_fifo_full = 1'b0;
        exp_q.delete();
        nxt();
        nxt();
        n_rst = 1'b1;
    endtask

    task automatic wait_req(output bit f, output logic [31:0] a);
        f = 1'b0;
        a = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_ic_en) begin
                f = 1'b1;
                a = bus.o_ic_addr;
                break;
            end
            nxt();
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) nxt();
    endtask

    task automatic test_reset();
        nxt();
        nxt();
        @(negedge clk);
        checks += 4;
        if (bus.o_ic_en !== 1'b0) begin errors++; $display("FAIL rst_ic_en: got %b required 0", bus.o_ic_en); end
        if (bus.o_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b required 0", bus.o_fifo_wr_en); end
        if (bus.o_ic_addr !== 32'h0) begin errors++; $display("FAIL rst_ic_addr: got %h required 0", bus.o_ic_addr); end
        if (bus.o_fifo_data_in !== 64'h0) begin errors++; $display("FAIL rst_data_in: got %h required 0", bus.o_fifo_data_in); end
        nxt();
        n_rst = 1'b1;
        @(negedge clk);
        checks += 2;
        if (bus.o_ic_en !== 1'b1) begin errors++; $display("FAIL first_req_en: got %b required 1", bus.o_ic_en); end
        if (bus.o_ic_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h required 0", bus.o_ic_addr); end
    endtask

    task automatic test_basic();
        mem_fixed = 1'b1;
        lat = 1;
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back({32'(4 * i), 32'h13});
        nxt();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_fifo_wr_en !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL basic_wr_pattern[%0d]: got %b required %b", i, bus.o_fifo_wr_en, i % 2 == 0);
            end
            nxt();
        end
        @(negedge clk);
        checks += 3;
        if (bus.o_ic_en !== 1'b1) begin errors++; $display("FAIL basic_next_en: got %b required 1", bus.o_ic_en); end
        if (bus.o_ic_addr !== 32'hC) begin errors++; $display("FAIL basic_next_addr: got %h required c", bus.o_ic_addr); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_full();
        mem_fixed = 1'b0;
        salt = 32'h0;
        lat = 1;
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back({32'(4 * i), memf(32'(4 * i))});
        repeat (4) nxt();
        bus.i_fifo_full = 1'b1;
        nxt();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL full_hold_wr[%0d]: got %b required 0", i, bus.o_fifo_wr_en); end
            nxt();
        end
        bus.i_fifo_full = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_fifo_wr_en !== 1'b1) begin errors++; $display("FAIL full_release_wr: got %b required 1", bus.o_fifo_wr_en); end
        nxt();
        @(negedge clk);
        checks += 3;
        if (bus.o_ic_en !== 1'b1) begin errors++; $display("FAIL full_next_en: got %b required 1", bus.o_ic_en); end
        if (bus.o_ic_addr !== 32'hC) begin errors++; $display("FAIL full_next_addr: got %h required c", bus.o_ic_addr); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_redirect_drop();
        mem_fixed = 1'b0;
        salt = 32'h5A5A;
        lat = 3;
        do_reset();
        exp_q.push_back({32'h0, memf(32'h0)});
        repeat (5) nxt();
        bus.i_redirect = 1'b1;
        bus.i_redirect_addr = 32'h100;
        @(negedge clk);
        checks += 2;
        if (bus.o_ic_en !== 1'b0) begin errors++; $display("FAIL drop_redir_en: got %b required 0", bus.o_ic_en); end
        if (bus.o_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL drop_redir_wr: got %b required 0", bus.o_fifo_wr_en); end
        nxt();
        bus.i_redirect = 1'b0;
        exp_q.push_back({32'h100, memf(32'h100)});
        wait_req(found, req_addr);
        checks++;
        if (!found || req_addr !== 32'h100) begin errors++; $display("FAIL drop_next_req: found=%b addr=%h required addr 100", found, req_addr); end
        nxt();
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL drop_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_redirect_valid();
        mem_fixed = 1'b0;
        salt = 32'h0;
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back({32'(4 * i), memf(32'(4 * i))});
        repeat (9) nxt();
        bus.i_redirect = 1'b1;
        bus.i_redirect_addr = 32'h200;
        @(negedge clk);
        checks += 2;
        if (bus.o_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rv_wr: got %b required 0", bus.o_fifo_wr_en); end
        if (bus.o_ic_en !== 1'b0) begin errors++; $display("FAIL rv_en: got %b required 0", bus.o_ic_en); end
        nxt();
        bus.i_redirect = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.o_ic_en !== 1'b1) begin errors++; $display("FAIL rv_next_en: got %b required 1", bus.o_ic_en); end
        if (bus.o_ic_addr !== 32'h200) begin errors++; $display("FAIL rv_next_addr: got %h required 200", bus.o_ic_addr); end
        exp_q.push_back({32'h200, memf(32'h200)});
        nxt();
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rv_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        mem_fixed = 1'b0;
        salt = 32'h0;
        lat = 1;
        do_reset();
        bus.i_redirect = 1'b1;
        bus.i_redirect_addr = 32'hFFFF_FFFC;
        @(negedge clk);
        checks++;
        if (bus.o_ic_en !== 1'b0) begin errors++; $display("FAIL wrap_cancel_en: got %b required 0", bus.o_ic_en); end
        nxt();
        bus.i_redirect = 1'b0;
        exp_q.push_back({32'hFFFF_FFFC, memf(32'hFFFF_FFFC)});
        exp_q.push_back({32'h0, memf(32'h0)});
        @(negedge clk);
        checks++;
        if (bus.o_ic_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_addr: got %h required fffffffc", bus.o_ic_addr); end
        nxt();
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d pending, required 0", exp_q.size()); end
        wait_req(found, req_addr);
        checks++;
        if (!found || req_addr !== 32'h4) begin errors++; $display("FAIL wrap_next_req: found=%b addr=%h required addr 4", found, req_addr); end
    endtask

    task automatic test_reset_hold();
        mem_fixed = 1'b0;
        salt = 32'h1111;
        lat = 1;
        do_reset();
        bus.i_fifo_full = 1'b1;
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if (bus.o_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rh_hold_wr: got %b required 0", bus.o_fifo_wr_en); end
        nxt();
        n_rst = 1'b0;
        bus.i_fifo_full = 1'b0;
        @(negedge clk);
        checks += 4;
        if (bus.o_ic_en !== 1'b0) begin errors++; $display("FAIL rh_rst_en: got %b required 0", bus.o_ic_en); end
        if (bus.o_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rh_rst_wr: got %b required 0", bus.o_fifo_wr_en); end
        if (bus.o_ic_addr !== 32'h0) begin errors++; $display("FAIL rh_rst_addr: got %h required 0", bus.o_ic_addr); end
        if (bus.o_fifo_data_in !== 64'h0) begin errors++; $display("FAIL rh_rst_data: got %h required 0", bus.o_fifo_data_in); end
        nxt();
        nxt();
        salt = 32'h2222;
        n_rst = 1'b1;
        exp_q.push_back({32'h0, memf(32'h0)});
        @(negedge clk);
        checks += 2;
        if (bus.o_ic_en !== 1'b1) begin errors++; $display("FAIL rh_first_en: got %b required 1", bus.o_ic_en); end
        if (bus.o_ic_addr !== 32'h0) begin errors++; $display("FAIL rh_first_addr: got %h required 0", bus.o_ic_addr); end
        nxt();
        wait_drain();
        bus.i_fifo_full = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rh_drain: %0d pending, required 0", exp_q.size()); end
        repeat (4) nxt();
    endtask

    initial begin
        n_rst = 1'b0;
        bus.i_redirect = 1'b0;
        bus.i_redirect_addr = '0;
        bus.i_fifo_full = 1'b0;
        bus.i_ic_valid = 1'b0;
        bus.i_ic_data = '0;
        test_reset();
        test_basic();
        test_full();
        test_redirect_drop();
        test_redirect_valid();
        test_wrap();
        test_reset_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 32, PC/instruction address width.
REQ-003 Parameter RESET_ADDR, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 n_rst  input  1  asynchronous, active-low reset.
REQ-006 i_redirect  input  1  redirect request from reorder buffer (o_redirect).
REQ-007 i_redirect_addr  input  ADDR_WIDTH  new fetch PC, valid with i_redirect.
REQ-008 o_ic_en  output  1  instruction memory read request, one cycle per request.
REQ-009 o_ic_addr  output  ADDR_WIDTH  request address (current PC).
REQ-010 i_ic_valid  input  1  read response valid; memory latency >= 1 cycle, variable.
REQ-011 i_ic_data  input  DATA_WIDTH  instruction word, valid with i_ic_valid.
REQ-012 o_fifo_wr_en  output  1  insn FIFO write enable (fifo_wr_if wr_en).
REQ-013 o_fifo_data_in  output  ADDR_WIDTH+DATA_WIDTH  {pc, insn}; PC in upper ADDR_WIDTH bits (fifo_wr_if data_in).
REQ-014 i_fifo_full  input  1  insn FIFO full (fifo_wr_if full).

Function
REQ-015 Block SHALL be the write-side producer of the instruction FIFO consumed by dispatch; at most one memory request outstanding.
REQ-016 States SHALL be REQ, WAIT, HOLD, DROP, encoded in a registered state variable.
REQ-017 REQ: o_ic_en=1, o_ic_addr=pc; next state WAIT (memory accepts every request, no ready).
REQ-018 WAIT, i_ic_valid=1, i_fifo_full=0: o_fifo_wr_en=1 same cycle, o_fifo_data_in={pc,i_ic_data}; pc <= pc+4; next REQ.
REQ-019 WAIT, i_ic_valid=1, i_fifo_full=1: capture i_ic_data into hold register; next HOLD; no write.
REQ-020 WAIT, i_ic_valid=0: remain WAIT.
REQ-021 HOLD: o_fifo_wr_en = !i_fifo_full, data {pc,hold}; on write pc <= pc+4, next REQ; else remain HOLD.
REQ-022 DROP: o_ic_en=0; response on i_ic_valid SHALL be discarded (no FIFO write); next REQ.
REQ-023 i_redirect SHALL have priority over all other events: pc <= i_redirect_addr; o_fifo_wr_en forced 0 that cycle; o_ic_en forced 0 that cycle.
REQ-024 Redirect next state: WAIT with i_ic_valid=0 -> DROP; DROP with i_ic_valid=0 -> DROP; all other cases (REQ, HOLD, WAIT/DROP with i_ic_valid=1) -> REQ; hold register contents discarded.
REQ-025 A REQ-state request cancelled by redirect SHALL not be issued (o_ic_en=0), so no response is expected.
REQ-026 PC increment SHALL be modulo 2^ADDR_WIDTH (wrap from all-ones-minus-3 to 0, no error).
REQ-027 o_fifo_wr_en SHALL never assert while i_fifo_full=1.
REQ-028 FIFO contents on redirect are flushed externally (i_flush to sync_fifo); block does not drive flush.
REQ-029 Steady-state throughput SHALL be one instruction per 2 cycles for 1-cycle memory latency.

Reset
REQ-030 While n_rst=0: state=REQ, pc=RESET_ADDR, hold=0, o_ic_en=0, o_fifo_wr_en=0, o_ic_addr=RESET_ADDR, o_fifo_data_in=0.
REQ-031 First request SHALL issue on the first rising edge after n_rst deasserts (o_ic_en=1, addr RESET_ADDR, combinationally in REQ once reset released).
REQ-032 Reset asserted mid-operation (WAIT/HOLD/DROP) SHALL return to REQ with pc=RESET_ADDR; a later stale i_ic_valid in REQ SHALL be ignored.

Verification
REQ-033 Reset release, 1-cycle memory returning 0x13 -> FIFO writes {0x0,0x13},{0x4,0x13},{0x8,0x13} on alternating cycles.
REQ-034 i_fifo_full=1 when response for PC 0x8 arrives, held 3 cycles -> no write while full; single write {0x8,data} the cycle full drops; next request at 0xC.
REQ-035 Memory latency 3, redirect to 0x100 one cycle after request to 0x4 -> DROP; stale response discarded; next request addr 0x100; first write PC 0x100.
REQ-036 Redirect to 0x200 in the same cycle as i_ic_valid for PC 0x10 -> no FIFO write; next state REQ; request addr 0x200.
REQ-037 Redirect to 0xFFFFFFFC -> writes PC 0xFFFFFFFC then 0x0 (wrap).
REQ-038 n_rst pulsed low while in HOLD -> outputs zero during reset; first request after release at RESET_ADDR; held word never written.
